serial_alu_core: RTL and testbench

- Bit-serial ALU that computes one bit per clock, LSB first, using the same bit-slice semantics as the combinational ALU (Ainvert/Binvert/CarryIn/Operation, Less/Set/Overflow at the MSB).
- It serves as the low-area alternative execution stage. A start/ready handshake accepts an operation from upstream control, and a one-cycle done pulse hands registered result and flags downstream.

---
 rtl/serial_alu_core_if.sv | 26 ++
 rtl/serial_alu_core.sv | 139 +++++++++++++
 tb/tb_serial_alu_core.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_alu_core_if.sv
// Start/ready request and done/result response bundle for the bit-serial ALU.
// The master side is upstream control; the slave side is the ALU core.
interface serial_alu_core_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             carry_out;
  logic             done;

  modport master (
    output start, a, b, alu_control,
    input  ready, result, zero, overflow, carry_out, done
  );

  modport slave (
    input  start, a, b, alu_control,
    output ready, result, zero, overflow, carry_out, done
  );
endinterface

// File: rtl/serial_alu_core.sv
// Bit-serial ALU: one bit slice per clock, LSB first, with the same slice
// semantics as the combinational ALU (invert/carry/operation, SLT via MSB set).
module serial_alu_core #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  serial_alu_core_if.slave  bus
);
  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] result_q;
  logic             a_inv;
  logic             b_inv;
  logic [1:0]       op;
  logic             carry;
  logic             set_q;
  logic             ovf_q;
  logic             cout_q;
  logic [IDX_W-1:0] idx;
  logic             ready_q;
  logic             done_q;
  logic             zero_q;
  logic             overflow_q;
  logic             carry_out_q;

  logic             ai;
  logic             bi;
  logic             sum;
  logic             carry_next;
  logic             slice;
  logic             ovf_bit;
  logic [WIDTH-1:0] final_result;

  // Current slice works on bit 0 of the operand shift registers.
  always_comb begin
    ai         = a_sh[0] ^ a_inv;
    bi         = b_sh[0] ^ b_inv;
    sum        = ai ^ bi ^ carry;
    carry_next = (ai & bi) | (ai & carry) | (bi & carry);
    ovf_bit    = (ai & bi & ~sum) | (~ai & ~bi & sum);
    slice      = 1'b0;
    case (op)
      2'b00:   slice = ai & bi;
      2'b01:   slice = ai | bi;
      2'b10:   slice = sum;
      default: slice = 1'b0;
    endcase
    final_result = result_q;
    if (op == 2'b11) begin
      final_result[0] = set_q;
    end
  end

  // Result shifts in from the MSB so that after WIDTH slices bit 0 sits at the LSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      result_q    <= '0;
      a_inv       <= 1'b0;
      b_inv       <= 1'b0;
      op          <= 2'b00;
      carry       <= 1'b0;
      set_q       <= 1'b0;
      ovf_q       <= 1'b0;
      cout_q      <= 1'b0;
      idx         <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      carry_out_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh     <= bus.a;
            b_sh     <= bus.b;
            a_inv    <= bus.alu_control[3];
            b_inv    <= bus.alu_control[2];
            op       <= bus.alu_control[1:0];
            carry    <= bus.alu_control[2];
            result_q <= '0;
            idx      <= '0;
            ready_q  <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          result_q <= {slice, result_q[WIDTH-1:1]};
          carry    <= carry_next;
          a_sh     <= a_sh >> 1;
          b_sh     <= b_sh >> 1;
          if (idx == LAST_IDX) begin
            set_q  <= sum;
            ovf_q  <= ovf_bit;
            cout_q <= carry_next;
            state  <= FIX;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        FIX: begin
          result_q    <= final_result;
          overflow_q  <= ovf_q & (op == 2'b10);
          carry_out_q <= cout_q & (op == 2'b10);
          zero_q      <= ~|final_result;
          done_q      <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;
  assign bus.carry_out = carry_out_q;
endmodule

// File: tb/tb_serial_alu_core.sv
// Directed bench for serial_alu_core (WIDTH = 32): each scenario task drives
// an operation and compares against hand-computed results and flags.
module tb_serial_alu_core;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_alu_core_if #(.WIDTH(32)) bus ();

  serial_alu_core #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits for ready, issues one request, scrambles operands after accept,
  // and returns the number of edges from accept until done is seen.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        input logic [3:0] ctl, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (bus.ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (bus.ready !== 1'b1) begin
      checks++; errors++;
      $display("[TB] FAIL ready_wait ready=%b required 1", bus.ready);
    end
    bus.a = av; bus.b = bv; bus.alu_control = ctl; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = ~av; bus.b = ~bv; bus.alu_control = ~ctl;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (bus.done !== 1'b1) begin
      checks++; errors++;
      $display("[TB] FAIL done_timeout done=%b required 1", bus.done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.alu_control = '0;
    #12;
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", bus.ready); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("[TB] FAIL reset_result got %h want 0", bus.result); end
    checks++; if ({bus.zero, bus.overflow, bus.carry_out} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_flags got %b want 000", {bus.zero, bus.overflow, bus.carry_out});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add_overflow();
    int lat;
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, lat);
    checks++; if (lat != 33) begin errors++; $display("[TB] FAIL add_latency got %0d want 33", lat); end
    checks++; if (bus.result !== 32'h8000_0000) begin errors++; $display("[TB] FAIL add_result got %h want 80000000", bus.result); end
    checks++; if ({bus.zero, bus.overflow, bus.carry_out} !== 3'b010) begin
      errors++; $display("[TB] FAIL add_flags got %b want 010", {bus.zero, bus.overflow, bus.carry_out});
    end
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0 || bus.result !== 32'h8000_0000) begin
      errors++; $display("[TB] FAIL add_hold done=%b result=%h want 0/80000000", bus.done, bus.result);
    end
  endtask

  task automatic test_sub_zero();
    int lat;
    run_op(32'h0000_0005, 32'h0000_0005, 4'b0110, lat);
    checks++; if (lat != 33) begin errors++; $display("[TB] FAIL sub_latency got %0d want 33", lat); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("[TB] FAIL sub_result got %h want 00000000", bus.result); end
    checks++; if ({bus.zero, bus.overflow, bus.carry_out} !== 3'b101) begin
      errors++; $display("[TB] FAIL sub_flags got %b want 101", {bus.zero, bus.overflow, bus.carry_out});
    end
  endtask

  task automatic test_reset_midrun();
    int guard;
    int done_seen;
    int lat;
    @(negedge clk);
    guard = 0;
    while (bus.ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    bus.a = 32'hFFFF_FFFF; bus.b = 32'h0; bus.alu_control = 4'b0010; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready got %b want 1", bus.ready); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("[TB] FAIL midrst_result got %h want 0", bus.result); end
    checks++; if ({bus.zero, bus.overflow, bus.carry_out, bus.done} !== 4'b0000) begin
      errors++; $display("[TB] FAIL midrst_flags got %b want 0000", {bus.zero, bus.overflow, bus.carry_out, bus.done});
    end
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) done_seen++;
    end
    checks++; if (done_seen != 0) begin errors++; $display("[TB] FAIL midrst_no_done got %0d pulses want 0", done_seen); end
    run_op(32'h1, 32'h2, 4'b0010, lat);
    checks++; if (bus.result !== 32'h3 || lat != 33) begin
      errors++; $display("[TB] FAIL midrst_fresh_add got %h lat %0d want 00000003 lat 33", bus.result, lat);
    end
  endtask

  task automatic test_slt();
    int lat;
    run_op(32'd3, 32'd7, 4'b0111, lat);
    checks++; if (bus.result !== 32'h1) begin errors++; $display("[TB] FAIL slt_3_7 got %h want 00000001", bus.result); end
    checks++; if ({bus.zero, bus.overflow, bus.carry_out} !== 3'b000) begin
      errors++; $display("[TB] FAIL slt_3_7_flags got %b want 000", {bus.zero, bus.overflow, bus.carry_out});
    end
    run_op(32'd7, 32'd3, 4'b0111, lat);
    checks++; if (bus.result !== 32'h0) begin errors++; $display("[TB] FAIL slt_7_3 got %h want 00000000", bus.result); end
    checks++; if ({bus.zero, bus.overflow, bus.carry_out} !== 3'b100) begin
      errors++; $display("[TB] FAIL slt_7_3_flags got %b want 100", {bus.zero, bus.overflow, bus.carry_out});
    end
  endtask

  task automatic test_logic();
    int lat;
    run_op(32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'b1100, lat);
    checks++; if (bus.result !== 32'h0 || bus.zero !== 1'b1) begin
      errors++; $display("[TB] FAIL nor got %h zero %b want 00000000 zero 1", bus.result, bus.zero);
    end
    run_op(32'hFFFF_0000, 32'h0F0F_0F0F, 4'b0000, lat);
    checks++; if (bus.result !== 32'h0F0F_0000 || bus.zero !== 1'b0) begin
      errors++; $display("[TB] FAIL and got %h zero %b want 0F0F0000 zero 0", bus.result, bus.zero);
    end
    run_op(32'hFFFF_0000, 32'h0F0F_0F0F, 4'b0001, lat);
    checks++; if (bus.result !== 32'hFFFF_0F0F || {bus.overflow, bus.carry_out} !== 2'b00) begin
      errors++; $display("[TB] FAIL or got %h ovf/cout %b want FFFF0F0F 00", bus.result, {bus.overflow, bus.carry_out});
    end
  endtask

  task automatic test_back_to_back();
    int guard;
    int ready_bad;
    int done_early;
    int lat;
    @(negedge clk);
    guard = 0;
    while (bus.ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    bus.a = 32'h7FFF_FFFF; bus.b = 32'h1; bus.alu_control = 4'b0010; bus.start = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_accept_ready got %b want 0", bus.ready); end
    bus.a = 32'h1; bus.b = 32'h1;
    ready_bad = 0;
    done_early = 0;
    for (int e = 1; e <= 33; e++) begin
      @(posedge clk); #1;
      if (bus.ready !== 1'b0) ready_bad++;
      if (e < 33 && bus.done === 1'b1) done_early++;
    end
    checks++; if (ready_bad != 0 || done_early != 0) begin
      errors++; $display("[TB] FAIL b2b_busy ready_high=%0d early_done=%0d want 0/0", ready_bad, done_early);
    end
    checks++; if (bus.done !== 1'b1 || bus.result !== 32'h8000_0000 || bus.overflow !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_first done=%b result=%h ovf=%b want 1/80000000/1", bus.done, bus.result, bus.overflow);
    end
    @(posedge clk); #1;
    checks++; if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_idle ready=%b done=%b want 1/0", bus.ready, bus.done);
    end
    @(posedge clk); #1;
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_second_accept ready=%b want 0", bus.ready); end
    bus.start = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (bus.done !== 1'b1 || lat != 34 || bus.result !== 32'h2) begin
      errors++; $display("[TB] FAIL b2b_second done=%b lat=%0d result=%h want 1/34/00000002", bus.done, lat, bus.result);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add_overflow();
    test_sub_zero();
    test_reset_midrun();
    test_slt();
    test_logic();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
